// File: rtl/door_sequencer.sv
// Tick-timed sliding door sequencer: prescaled tick, timed travel/hold, obstacle reversal.
// Define DOOR_SEQ_FAULT_EN to build the retry counter, FAULT state, alarm and ack handling.
module door_sequencer #(
    parameter int TICK_DIV     = 50000000,
    parameter int TRAVEL_TICKS = 3,
    parameter int HOLD_TICKS   = 10,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense,
    input  logic       obs,
    input  logic       ack,
    output logic [1:0] motor,
    output logic       alarm,
    output logic       tick,
    output logic [2:0] state
);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int MAXT = (HOLD_TICKS > TRAVEL_TICKS) ? HOLD_TICKS : TRAVEL_TICKS;
    localparam int CW   = $clog2(MAXT) + 1;

    typedef enum logic [2:0] {
        S_CLOSED    = 3'd0,
        S_OPENING   = 3'd1,
        S_OPEN_HOLD = 3'd2,
        S_CLOSING   = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [1:0] M_STOP  = 2'b00;
    localparam logic [1:0] M_OPEN  = 2'b01;
    localparam logic [1:0] M_CLOSE = 2'b10;

    state_t          state_q, state_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [CW-1:0]   trav_q, trav_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [1:0]      motor_q, motor_d;

    assign tick  = (pre_q == PW'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign motor = motor_q;
    assign state = state_q;

`ifdef DOOR_SEQ_FAULT_EN
    localparam int RW = $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] retry_q, retry_d;
    logic          alarm_q;

    assign alarm = alarm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            alarm_q <= (state_d == S_FAULT);
        end
    end
`else
    logic unused_ack;
    assign unused_ack = ack;
    assign alarm      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_CLOSED;
            pre_q   <= '0;
            trav_q  <= '0;
            hold_q  <= '0;
            motor_q <= M_STOP;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            trav_q  <= trav_d;
            hold_q  <= hold_d;
            motor_q <= motor_d;
        end
    end

    always_comb begin
        state_d = state_q;
        trav_d  = trav_q;
        hold_d  = hold_q;
`ifdef DOOR_SEQ_FAULT_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_CLOSED: begin
                if (tick && sense) begin
                    state_d = S_OPENING;
                    trav_d  = CW'(TRAVEL_TICKS);
                end
            end
            S_OPENING: begin
                if (tick) begin
                    if (trav_q <= CW'(1)) begin
                        trav_d  = '0;
                        state_d = S_OPEN_HOLD;
                        hold_d  = CW'(HOLD_TICKS);
                    end else begin
                        trav_d = trav_q - 1'b1;
                    end
                end
            end
            S_OPEN_HOLD: begin
                if (tick) begin
                    if (sense || obs) begin
                        hold_d = CW'(HOLD_TICKS);
                    end else if (hold_q <= CW'(1)) begin
                        hold_d  = '0;
                        state_d = S_CLOSING;
                        trav_d  = CW'(TRAVEL_TICKS);
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
            end
            S_CLOSING: begin
                // obs beats sense beats expiry, so an obstacle on the last tick still reverses
                if (tick) begin
                    if (obs) begin
`ifdef DOOR_SEQ_FAULT_EN
                        if (retry_q >= RW'(MAX_RETRIES - 1)) begin
                            retry_d = RW'(MAX_RETRIES);
                            state_d = S_FAULT;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_OPENING;
                            trav_d  = CW'(TRAVEL_TICKS);
                        end
`else
                        state_d = S_OPENING;
                        trav_d  = CW'(TRAVEL_TICKS);
`endif
                    end else if (sense) begin
                        state_d = S_OPENING;
                        trav_d  = CW'(TRAVEL_TICKS);
                    end else if (trav_q <= CW'(1)) begin
                        trav_d  = '0;
                        state_d = S_CLOSED;
`ifdef DOOR_SEQ_FAULT_EN
                        retry_d = '0;
`endif
                    end else begin
                        trav_d = trav_q - 1'b1;
                    end
                end
            end
`ifdef DOOR_SEQ_FAULT_EN
            S_FAULT: begin
                // ack is a per-clock level, not tick-gated
                if (ack && !obs) begin
                    state_d = S_OPEN_HOLD;
                    hold_d  = CW'(HOLD_TICKS);
                    retry_d = '0;
                end
            end
`endif
            default: state_d = S_CLOSED;
        endcase
    end

    always_comb begin
        motor_d = M_STOP;
        case (state_d)
            S_OPENING: motor_d = M_OPEN;
            S_CLOSING: motor_d = M_CLOSE;
            default:   motor_d = M_STOP;
        endcase
    end
endmodule

// File: doc/door_sequencer.md
# door_sequencer

Tick-timed sequencer for the automatic sliding door. It converts presence (`sense`) and obstacle (`obs`) inputs into motor commands with timed travel, a timed open-hold, and obstacle reversal, and latches a fault after repeated obstructed closings. It sits between the door sensors and the motor driver and replaces free-running per-second state stepping with counted travel and hold intervals.

## Interface
Parameters:
- `TICK_DIV`, default 50000000: clocks per FSM tick (1 Hz at 50 MHz); must be ≥2.
- `TRAVEL_TICKS`, default 3: ticks the motor runs for a full open or a full close; must be ≥1.
- `HOLD_TICKS`, default 10: idle ticks the door stays open before closing; must be ≥1.
- `MAX_RETRIES`, default 3: obstacle reversals allowed before FAULT; must be ≥1.

Ports:
- `clk` in 1: main clock.
- `rst` in 1: reset, asynchronous, active-high.
- `sense` in 1: presence sensor, level.
- `obs` in 1: obstacle sensor, level.
- `ack` in 1: operator fault acknowledge, level, sampled every clock.
- `motor` out 2: 00 = stop, 01 = open, 10 = close; 11 is never driven.
- `alarm` out 1: high while in FAULT.
- `tick` out 1: one-clock pulse once every `TICK_DIV` clocks.
- `state` out 3: current state encoding, for debug and LEDs.

## Operation
- Prescaler: counts 0..`TICK_DIV`-1 and wraps. `tick` is high in the cycle where the count equals `TICK_DIV`-1.
- Except for `ack`, `sense` and `obs` are evaluated and states change only on `tick` cycles.
- States and encodings: CLOSED=0, OPENING=1, OPEN_HOLD=2, CLOSING=3, FAULT=4.
- CLOSED (motor 00):
  - `sense`=1 → OPENING, travel counter loaded with `TRAVEL_TICKS`.
  - `obs` is ignored in this state.
- OPENING (motor 01):
  - Each tick decrements the travel counter.
  - On the tick where the counter reaches 0 → OPEN_HOLD, hold counter loaded with `HOLD_TICKS`.
- OPEN_HOLD (motor 00):
  - A tick with `sense` or `obs` high reloads the hold counter with `HOLD_TICKS`.
  - Otherwise the tick decrements the counter; on reaching 0 → CLOSING, travel counter loaded with `TRAVEL_TICKS`.
- CLOSING (motor 10):
  - `obs`=1 → retry counter +1. If the new count equals `MAX_RETRIES` → FAULT; otherwise → OPENING, travel counter = `TRAVEL_TICKS`.
  - Else `sense`=1 → OPENING, travel counter = `TRAVEL_TICKS`, retry counter unchanged.
  - Else decrement; on reaching 0 → CLOSED and the retry counter clears.
- FAULT (motor 00, alarm 1):
  - On any clock edge with `ack`=1 and `obs`=0 → OPEN_HOLD, hold counter = `HOLD_TICKS`, retry counter cleared.
  - `ack` is ignored while `obs`=1.
- Priority in CLOSING when events coincide: `obs` > `sense` > counter expiry. An obstacle on the final closing tick still reverses the door.
- Counters are sized by `$clog2` of the larger of `HOLD_TICKS` and `TRAVEL_TICKS`, plus 1. The retry counter is sized for `MAX_RETRIES` and saturates there.

## Timing
- `motor`, `alarm` and `state` are registered Moore outputs. They change on the clock edge that follows the deciding `tick` cycle, i.e. one clock of latency.
- `ack` exits FAULT one clock after it is sampled high.
- Reset values: `motor`=00, `alarm`=0, `tick`=0, `state`=0 (CLOSED); prescaler, travel, hold and retry counters all 0.
- Reset mid-operation forces `motor`=00 immediately (asynchronous). On release, the prescaler restarts from 0, so the first tick comes `TICK_DIV` clocks after reset deassertion.
- Nominal full cycle with no inputs after the opening request: `TRAVEL_TICKS` + `HOLD_TICKS` + `TRAVEL_TICKS` ticks from leaving CLOSED to returning to CLOSED.

## Configuration
- `DOOR_SEQ_FAULT_EN` defined: the retry counter and FAULT state are built, and `alarm` and `ack` behave as described above.
- Not defined: there is no retry counter and no FAULT state. Every obstacle in CLOSING reverses to OPENING without limit, `alarm` is tied to 0, `ack` is ignored, and state 4 is unreachable.

## Test plan
All scenarios use `TICK_DIV`=4, `TRAVEL_TICKS`=2, `HOLD_TICKS`=3, `MAX_RETRIES`=2, with the macro defined unless noted.
- Reset, then hold `sense`=1 across one tick and drop it → `motor` sequence 01 (8 clocks), 00 (12 clocks), 10 (8 clocks), then 00 with `state`=0; `alarm` stays 0 throughout.
- Keep `sense`=1 for 5 ticks while in OPEN_HOLD → `motor` stays 00; CLOSING begins exactly 3 ticks after the last tick that saw `sense` high.
- `obs`=1 on the second CLOSING tick → `motor`=01 one clock after that tick, `state`=1, `alarm`=0, retry count 1.
- A second obstructed closing → `state`=4, `motor`=00, `alarm`=1. `ack`=1 with `obs`=1 leaves it in FAULT. `ack`=1 with `obs`=0 gives `state`=2 and `alarm`=0 one clock later.
- Assert `rst` mid-OPENING → `motor`=00 and `state`=0 without waiting for a clock edge. After release, the first `tick` arrives 4 clocks later.
- With the macro undefined, 5 consecutive obstructed closings → each one returns to OPENING, `alarm` stays 0, and `state` is never 4.
